mcu_tx_arbiter: RTL
===================

Name: mcu_tx_arbiter

Overview:
- Shares the single MCU-link UART transmitter between several frame sources: parameter-setting reply, travelling-wave upload, power-frequency upload and status reply.
- Grants are frame-level and round-robin. The owner keeps the UART until it drops its request, so frames never interleave.
- Muxes the owner's tx_data/start_tx to the UART core and returns per-requester byte-done pulses.
- Replaces ad-hoc selection on module_run_flag-style signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 1_000_000, owned cycles with no byte activity before forced release
- TO_W, 20, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-source frame request; held high for the whole frame
- start_tx_in  in  NUM_REQ  per-source one-cycle byte start pulse
- tx_data_in  in  8*NUM_REQ  per-source byte; source i uses bits [8i+7:8i]
- tx_idle  in  1  UART TX core idle flag (high = idle); asynchronous to clk
- grant  out  NUM_REQ  one-hot owner indication
- tx_data  out  8  byte to the UART core
- start_tx  out  1  one-cycle start pulse to the UART core
- byte_done  out  NUM_REQ  one-cycle pulse to the owner when its byte finishes
- busy  out  1  high while any source owns the UART
- timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset values: grant=0, tx_data=0, start_tx=0, byte_done=0, busy=0, timeout_err=0. Internally: state=ARB, rr_ptr=0, in_flight=0, timeout counter=0, tx_idle synchronisers=1.
- Reset is honoured mid-frame with no drain; the UART core is responsible for finishing its own byte.
- tx_idle passes through a 2-FF synchroniser. done_edge is a sync-domain rising edge (idle returning high).
- in_flight is set on an issued start_tx and cleared on done_edge.
- FSM ARB:
  - If req is nonzero, select the first set bit searching from rr_ptr upward with wrap-around (e.g. rr_ptr=2, N=4 searches 2,3,0,1).
  - Register owner and assert grant[owner] and busy on the next clock, then go to OWN.
  - If req is zero, stay in ARB with outputs idle.
  - Minimum 1 cycle in ARB between frames.
- FSM OWN:
  - tx_data <= tx_data_in[owner] on every clock.
  - start_tx <= start_tx_in[owner] & ~in_flight & tx_idle_sync. Latency is 1 clk from the source pulse to start_tx, and the pulse is exactly 1 cycle.
  - A start pulse while in_flight or tx_idle_sync is low is dropped. Sources must wait for byte_done.
  - start_tx_in from non-owners is ignored in every state.
  - done_edge while in_flight produces byte_done[owner] for 1 cycle.
  - Release condition: req[owner]==0 and in_flight==0 and tx_idle_sync==1. On release: grant=0, busy=0, rr_ptr=(owner+1) mod NUM_REQ, go to ARB.
  - If req drops while a byte is in flight, stay in OWN until done_edge; byte_done is still emitted.
- Timeout:
  - The counter counts in OWN and clears on start_tx, done_edge or leaving OWN.
  - At TIMEOUT_CYC-1: pulse timeout_err, clear in_flight, release as above even if req[owner] is still high, and advance rr_ptr.
  - A stuck source must re-win arbitration.
- Simultaneous events:
  - Release and new requests in the same cycle: the new owner is decided in the following ARB cycle using the updated rr_ptr.
  - start_tx_in and done_edge in the same cycle: byte_done fires and start is dropped, because the in_flight check uses the pre-clear value.
- Outputs are registered. There is no combinational path from req to grant.

Decomposition:
- Shared package or include file:
  - FSM state encodings: ARB and OWN.
  - The default TIMEOUT_CYC constant.
  - The requester index constants: REQ_PARA_REPLY=0, REQ_TW_UPLOAD=1, REQ_PF_UPLOAD=2, REQ_STATUS=3. These sit alongside the existing MCU packet command constants.
- One sub-module: rr_pick. It is a combinational round-robin first-one finder from rr_ptr, returning a valid flag and an index. Everything else stays in mcu_tx_arbiter.

Test Plan:
- Single source:
  - Stimulus: req[0] high; 7 bytes 0xAA,0x10,0x01,0x00,0xFF,crc,0x55, each start_tx_in[0] issued after byte_done[0]; UART model holds tx_idle low for 100 clk per byte.
  - Response: grant=4'b0001 within 2 clk of req; 7 start_tx pulses with matching tx_data; 7 byte_done[0] pulses; release 1 clk after req drops; rr_ptr=1.
- Contention:
  - Stimulus: req=4'b1011 asserted together from reset; each source sends a 2-byte frame then drops req.
  - Response: grant order 0,1,3; then on re-request of 0 and 1, order is 0,1; no grant overlap; busy low ≥1 clk between frames.
- Non-owner and early-start isolation:
  - Stimulus: while source 1 is owned, pulse start_tx_in[2] with data 0x33; source 1 pulses start while in_flight.
  - Response: no start_tx generated; tx_data never shows 0x33.
- req drop mid-byte:
  - Stimulus: owner drops req 10 clk after start_tx while tx_idle is low.
  - Response: grant held until done_edge; byte_done fires; release on the next cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYC=50; source 2 holds req with no start.
  - Response: timeout_err pulses at cycle 50 of OWN; grant clears; pending req[3] is granted next.
- Reset mid-frame:
  - Stimulus: assert rst for 1 clk during byte 3 of a frame.
  - Response: all outputs 0 the next cycle; rr_ptr=0; req[0] and req[1] both pending afterwards results in source 0 granted first.

Source files
------------

// File: rtl/mcu_tx_arbiter_pkg.sv
// mcu_tx_arbiter_pkg
//   Shared definitions for the MCU-link transmit arbiter: FSM state
//   encodings, the default forced-release timeout and the requester
//   slot assignments. The requester indices sit with the MCU packet
//   command constants so every source agrees on its grant bit.
package mcu_tx_arbiter_pkg;

    typedef enum logic {
        ARB = 1'b0,   // no owner, picking the next requester
        OWN = 1'b1    // one source owns the UART for a whole frame
    } arb_state_e;

    // Owned cycles with no byte activity before the owner is evicted.
    localparam int TIMEOUT_CYC_DEF = 1_000_000;

    // Requester slots (bit positions in req/grant/byte_done).
    localparam int REQ_PARA_REPLY = 0;
    localparam int REQ_TW_UPLOAD  = 1;
    localparam int REQ_PF_UPLOAD  = 2;
    localparam int REQ_STATUS     = 3;

endpackage

// File: rtl/mcu_tx_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin first-one finder. Searches req_i starting
//   at ptr_i and wrapping past the top (ptr=2, N=4 searches 2,3,0,1).
// Ports:
//   req_i  in  N      request vector
//   ptr_i  in  IDX_W  search start position (must be < N)
//   vld_o  out 1      any request set
//   idx_o  out IDX_W  index of the first set request found
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] j;

    // Walk the search order backwards so the last hit written is the
    // first in round-robin order; avoids a break in the loop.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (j >= (IDX_W + 1)'(N)) j = j - (IDX_W + 1)'(N);
            if (req_i[j[IDX_W-1:0]]) begin
                vld_o = 1'b1;
                idx_o = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mcu_tx_arbiter.sv
// mcu_tx_arbiter
//   Frame-level round-robin owner of the single MCU-link UART
//   transmitter. The owner keeps the UART until it drops req, so frames
//   never interleave; its byte/start are muxed to the UART core and the
//   core's idle return is turned into a byte_done pulse for the owner.
//   An owner that shows no byte activity for TIMEOUT_CYC cycles is
//   evicted and must re-win arbitration. All outputs are registered.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_i          per-source frame request (held for the whole frame)
//   start_tx_in_i  per-source one-cycle byte start
//   tx_data_in_i   per-source byte, source i at [8i+7:8i]
//   tx_idle_i      UART core idle flag (async to clk)
//   grant_o        one-hot owner
//   tx_data_o      byte to the UART core
//   start_tx_o     one-cycle start to the UART core
//   byte_done_o    one-cycle pulse to the owner when its byte finishes
//   busy_o         any source owns the UART
//   timeout_err_o  one-cycle pulse on forced release
module mcu_tx_arbiter
    import mcu_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     start_tx_in_i,
    input  logic [8*NUM_REQ-1:0]   tx_data_in_i,
    input  logic                   tx_idle_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             tx_data_o,
    output logic                   start_tx_o,
    output logic [NUM_REQ-1:0]     byte_done_o,
    output logic                   busy_o,
    output logic                   timeout_err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               in_flight_q, in_flight_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] bdone_q, bdone_d;
    logic               busy_q, busy_d;
    logic               to_err_q, to_err_d;
    logic               idle_s1_q, idle_s2_q, idle_s3_q;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               idle_sync, done_edge;
    logic               timeout_hit, rel;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    // s1/s2 form the synchroniser; s3 is only the previous s2 value so
    // that the idle rising edge is detected in the clk domain.
    assign idle_sync = idle_s2_q;
    assign done_edge = idle_s2_q & ~idle_s3_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        in_flight_d = in_flight_q;
        to_cnt_d    = '0;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        start_d     = 1'b0;
        bdone_d     = '0;
        busy_d      = busy_q;
        to_err_d    = 1'b0;
        timeout_hit = 1'b0;
        rel         = 1'b0;

        case (state_q)
            ARB: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (pick_vld) begin
                    owner_d           = pick_idx;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    state_d           = OWN;
                end
            end
            OWN: begin
                tx_data_d = tx_data_in_i[{owner_q, 3'b000} +: 8];
                // in_flight_q is the pre-clear value, so a start landing
                // on the same cycle as done_edge is dropped.
                start_d   = start_tx_in_i[owner_q] & ~in_flight_q & idle_sync;
                bdone_d[owner_q] = done_edge & in_flight_q;

                timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
                rel = timeout_hit |
                      (~req_i[owner_q] & ~in_flight_q & idle_sync);

                if (rel) begin
                    start_d  = 1'b0;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    to_err_d = timeout_hit;
                    state_d  = ARB;
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : owner_q + 1'b1;
                end else begin
                    to_cnt_d = (start_d | done_edge) ? '0 : to_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase

        if (done_edge)   in_flight_d = 1'b0;
        if (start_d)     in_flight_d = 1'b1;
        if (timeout_hit) in_flight_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            in_flight_q <= 1'b0;
            to_cnt_q    <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            start_q     <= 1'b0;
            bdone_q     <= '0;
            busy_q      <= 1'b0;
            to_err_q    <= 1'b0;
            idle_s1_q   <= 1'b1;
            idle_s2_q   <= 1'b1;
            idle_s3_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            in_flight_q <= in_flight_d;
            to_cnt_q    <= to_cnt_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            start_q     <= start_d;
            bdone_q     <= bdone_d;
            busy_q      <= busy_d;
            to_err_q    <= to_err_d;
            idle_s1_q   <= tx_idle_i;
            idle_s2_q   <= idle_s1_q;
            idle_s3_q   <= idle_s2_q;
        end
    end

    assign grant_o       = grant_q;
    assign tx_data_o     = tx_data_q;
    assign start_tx_o    = start_q;
    assign byte_done_o   = bdone_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = to_err_q;

endmodule
